// File: rtl/fetch_stage.sv
// fetch_stage: PC register, IF/ID register and variable-latency imem req/ack front end.
// Ports: clk/rst (async active-high); pcwrite, if_id_write, if_id_reg_flush, pcsrc,
//        branch_target from decode control; imem_req/imem_addr/imem_ack/imem_rdata
//        memory handshake; if_id_instr/if_id_pc_plus4/if_id_valid IF/ID contents;
//        fetch_pending = request outstanding without ack this cycle.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcwrite,
  input  logic        if_id_write,
  input  logic        if_id_reg_flush,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fetch_pending
);
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
  state_t      r_state;
  logic [31:0] r_pc, r_old_addr, r_hold_instr, r_instr, r_pc4;
  logic        r_valid;
  logic        w_redirect, w_flush, w_avail;
  logic [31:0] w_target, w_pc4, w_dinstr;
  assign w_redirect = pcwrite & (pcsrc == 2'b01 | pcsrc == 2'b10);
  assign w_flush    = pcwrite & if_id_reg_flush;
  assign w_target   = pcsrc == 2'b01 ? branch_target : {r_pc4[31:28], r_instr[25:0], 2'b00};
  assign w_pc4      = r_pc + 32'd4;
  // PC does not move while an instruction sits in the hold buffer, so pc+4 is still its link value
  assign w_avail    = ~w_redirect & ((r_state == FETCH & imem_ack) | r_state == HOLD);
  assign w_dinstr   = r_state == HOLD ? r_hold_instr : imem_rdata;
  assign imem_req       = r_state != HOLD;
  assign imem_addr      = r_state == DISCARD ? r_old_addr : r_pc;
  assign fetch_pending  = imem_req & ~imem_ack;
  assign if_id_instr    = r_instr;
  assign if_id_pc_plus4 = r_pc4;
  assign if_id_valid    = r_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_old_addr   <= RESET_PC;
      r_hold_instr <= NOP_INSTR;
      r_instr      <= NOP_INSTR;
      r_pc4        <= 32'h0;
      r_valid      <= 1'b0;
    end else begin
      if (w_flush) begin
        r_instr <= NOP_INSTR;
        r_pc4   <= 32'h0;
        r_valid <= 1'b0;
      end else if (if_id_write) begin
        r_instr <= w_avail ? w_dinstr : NOP_INSTR;
        r_pc4   <= w_avail ? w_pc4 : 32'h0;
        r_valid <= w_avail;
      end
      case (r_state)
        FETCH:
          if (imem_ack) begin
            if (w_redirect) r_pc <= w_target;
            else if (if_id_write) r_pc <= w_pc4;
            else begin
              r_hold_instr <= imem_rdata;
              r_state      <= HOLD;
            end
          end else if (w_redirect) begin
            // the in-flight response must still be consumed, so remember its address
            r_old_addr <= r_pc;
            r_pc       <= w_target;
            r_state    <= DISCARD;
          end
        HOLD:
          if (w_redirect) begin
            r_pc    <= w_target;
            r_state <= FETCH;
          end else if (if_id_write) begin
            r_pc    <= w_pc4;
            r_state <= FETCH;
          end
        default: begin
          if (w_redirect) r_pc <= w_target;
          if (imem_ack) r_state <= FETCH;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage handshake, redirect, stall and reset behaviour.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pcwrite = 1'b1, if_id_write = 1'b1, if_id_reg_flush = 1'b0;
  logic [1:0]  pcsrc = 2'b00;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0;
  logic [31:0] if_id_instr, if_id_pc_plus4;
  logic        if_id_valid, fetch_pending;
  int          n_cmp = 0, n_fail = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .pcwrite(pcwrite), .if_id_write(if_id_write),
    .if_id_reg_flush(if_id_reg_flush), .pcsrc(pcsrc), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
    .fetch_pending(fetch_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic pw, input logic iw,
                       input logic fl, input logic [1:0] src, input logic [31:0] bt);
    imem_ack = ack; imem_rdata = rdata; pcwrite = pw; if_id_write = iw;
    if_id_reg_flush = fl; pcsrc = src; branch_target = bt;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4", if_id_pc_plus4, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_req", {31'h0, imem_req}, 32'h1);
    chk("rel_addr", imem_addr, 32'h0);
    tick();
    // back-to-back single-cycle fetches, rdata = addr
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(4 * i), 1, 1, 0, 2'b00, 0);
      chk("seq_addr", imem_addr, 32'(4 * i));
      chk("seq_pend", {31'h0, fetch_pending}, 32'h0);
      tick();
      chk("seq_pc4", if_id_pc_plus4, 32'(4 * i + 4));
      chk("seq_instr", if_id_instr, 32'(4 * i));
      chk("seq_valid", {31'h0, if_id_valid}, 32'h1);
    end
    // three-cycle latency at 0x10
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 1, 0, 2'b00, 0);
      chk("lat_pend", {31'h0, fetch_pending}, 32'h1);
      chk("lat_addr", imem_addr, 32'h10);
      tick();
      chk("lat_bubble", {31'h0, if_id_valid}, 32'h0);
    end
    drive(1, 32'hABCD_0010, 1, 1, 0, 2'b00, 0);
    chk("lat_pend_ack", {31'h0, fetch_pending}, 32'h0);
    tick();
    chk("lat_pc4", if_id_pc_plus4, 32'h14);
    chk("lat_instr", if_id_instr, 32'hABCD_0010);
    chk("lat_valid", {31'h0, if_id_valid}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h5000 + 32'(i), 1, 1, 0, 2'b00, 0);
      tick();
    end
    // branch with flush while 0x20 is outstanding
    drive(0, 0, 1, 1, 1, 2'b01, 32'h100);
    chk("br_addr", imem_addr, 32'h20);
    tick();
    chk("br_flush", {31'h0, if_id_valid}, 32'h0);
    drive(0, 0, 1, 1, 0, 2'b00, 0);
    chk("dis_addr", imem_addr, 32'h20);
    chk("dis_req", {31'h0, imem_req}, 32'h1);
    chk("dis_pend", {31'h0, fetch_pending}, 32'h1);
    tick();
    drive(1, 32'hDEAD_0020, 1, 1, 0, 2'b00, 0);
    chk("dis_addr_ack", imem_addr, 32'h20);
    tick();
    chk("dis_drop", {31'h0, if_id_valid}, 32'h0);
    drive(1, 32'h1111_0100, 1, 1, 0, 2'b01, 32'h4000_0004);
    chk("br_target", imem_addr, 32'h100);
    tick();
    chk("br_ack_drop", {31'h0, if_id_valid}, 32'h0);
    // set up IF/ID for a jump, then jump with ack
    drive(1, 32'h0000_0040, 1, 1, 0, 2'b00, 0);
    chk("j_addr0", imem_addr, 32'h4000_0004);
    tick();
    chk("j_pc4", if_id_pc_plus4, 32'h4000_0008);
    drive(1, 32'h1234_5678, 1, 1, 0, 2'b10, 32'hFFFF_0000);
    chk("j_addr1", imem_addr, 32'h4000_0008);
    tick();
    chk("j_drop", {31'h0, if_id_valid}, 32'h0);
    chk("j_target", imem_addr, 32'h4000_0100);
    drive(1, 32'h2222_0000, 1, 1, 0, 2'b01, 32'h30);
    tick();
    // stall with ack at 0x30, redirect asserted during stall
    drive(1, 32'h0BAD_0030, 0, 0, 1, 2'b01, 32'h999);
    chk("st_addr", imem_addr, 32'h30);
    tick();
    chk("st_req", {31'h0, imem_req}, 32'h0);
    chk("st_pend", {31'h0, fetch_pending}, 32'h0);
    chk("st_hold_valid", {31'h0, if_id_valid}, 32'h0);
    drive(0, 0, 0, 0, 1, 2'b01, 32'h999);
    tick();
    chk("st_req2", {31'h0, imem_req}, 32'h0);
    drive(0, 0, 1, 1, 0, 2'b00, 0);
    tick();
    chk("st_instr", if_id_instr, 32'h0BAD_0030);
    chk("st_pc4", if_id_pc_plus4, 32'h34);
    chk("st_valid", {31'h0, if_id_valid}, 32'h1);
    chk("st_next", imem_addr, 32'h34);
    chk("st_req3", {31'h0, imem_req}, 32'h1);
    // redirect into DISCARD with IF/ID held, then async reset mid-cycle
    drive(0, 0, 1, 0, 0, 2'b01, 32'hFFFF_FFFC);
    tick();
    chk("pre_rst_valid", {31'h0, if_id_valid}, 32'h1);
    chk("pre_rst_addr", imem_addr, 32'h34);
    drive(0, 0, 1, 1, 0, 2'b00, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("arst_instr", if_id_instr, 32'h0);
    chk("arst_pc4", if_id_pc_plus4, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arel_addr", imem_addr, 32'h0);
    chk("arel_req", {31'h0, imem_req}, 32'h1);
    // PC wrap from 0xFFFF_FFFC
    drive(1, 32'h3333_0000, 1, 1, 0, 2'b01, 32'hFFFF_FFFC);
    tick();
    drive(1, 32'h0000_0077, 1, 1, 0, 2'b00, 0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc4", if_id_pc_plus4, 32'h0);
    chk("wrap_instr", if_id_instr, 32'h77);
    chk("wrap_valid", {31'h0, if_id_valid}, 32'h1);
    chk("wrap_next", imem_addr, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
